// File: rtl/ras_ckpt_stack.sv
// Return address stack with checkpoint restore.
// Circular flop array; index wraps, count saturates.
module ras_ckpt_stack #(
   parameter int RAS_ENTRIES = 16,
   parameter int PC_WIDTH = 38,
   localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       push_valid,
   input  logic [PC_WIDTH-1:0]        push_pc38,
   input  logic                       pop_valid,
   input  logic                       restore_valid,
   input  logic [LOG_RAS_ENTRIES-1:0] restore_index,
   input  logic [LOG_RAS_ENTRIES:0]   restore_count,
   input  logic                       restore_push_valid,
   input  logic                       restore_pop_valid,
   input  logic [PC_WIDTH-1:0]        restore_push_pc38,
   output logic [PC_WIDTH-1:0]        top_pc38,
   output logic [LOG_RAS_ENTRIES-1:0] ras_index,
   output logic [LOG_RAS_ENTRIES:0]   ras_count,
   output logic                       empty,
   output logic                       full
);

   localparam int CW = LOG_RAS_ENTRIES + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(RAS_ENTRIES);

   logic [PC_WIDTH-1:0]        stack_q [RAS_ENTRIES];
   logic [LOG_RAS_ENTRIES-1:0] index_q;
   logic [LOG_RAS_ENTRIES-1:0] index_d;
   logic [LOG_RAS_ENTRIES-1:0] base_index;
   logic [CW-1:0]              count_q;
   logic [CW-1:0]              count_d;
   logic [CW-1:0]              base_count;
   logic                       act_push;
   logic                       act_pop;
   logic [PC_WIDTH-1:0]        act_pc;
   logic                       wr_en;
   logic [LOG_RAS_ENTRIES-1:0] wr_index;

   // Pick base state and action: restore wins over the normal port.
   always_comb begin
      base_index = index_q;
      base_count = count_q;
      act_push   = push_valid;
      act_pop    = pop_valid;
      act_pc     = push_pc38;
      if (restore_valid) begin
         base_index = restore_index;
         base_count = (restore_count > MAX_CNT) ? MAX_CNT : restore_count;
         act_push   = restore_push_valid;
         act_pop    = restore_pop_valid;
         act_pc     = restore_push_pc38;
      end
   end

   // Apply push/pop to the base state.
   always_comb begin
      index_d  = base_index;
      count_d  = base_count;
      wr_en    = 1'b0;
      wr_index = base_index;
      if (act_push && act_pop) begin
         wr_en = 1'b1;
      end else if (act_push) begin
         index_d  = base_index + 1'b1;
         wr_index = base_index + 1'b1;
         wr_en    = 1'b1;
         count_d  = (base_count == MAX_CNT) ? MAX_CNT : base_count + 1'b1;
      end else if (act_pop) begin
         index_d = base_index - 1'b1;
         count_d = (base_count == '0) ? '0 : base_count - 1'b1;
      end
   end

   // State and array update; reset clears every entry.
   always_ff @(posedge CLK) begin
      if (rst) begin
         index_q <= '0;
         count_q <= '0;
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         index_q <= index_d;
         count_q <= count_d;
         if (wr_en) begin
            stack_q[wr_index] <= act_pc;
         end
      end
   end

   assign top_pc38  = stack_q[index_q];
   assign ras_index = index_q;
   assign ras_count = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == MAX_CNT);

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench for ras_ckpt_stack.
// Directed vectors; monitor checks on the falling edge.
module tb_ras_ckpt_stack;

   localparam int N  = 16;
   localparam int PW = 38;
   localparam int LW = 4;

   logic          CLK = 1'b0;
   logic          rst = 1'b0;
   logic          push_valid = 1'b0;
   logic [PW-1:0] push_pc38 = '0;
   logic          pop_valid = 1'b0;
   logic          restore_valid = 1'b0;
   logic [LW-1:0] restore_index = '0;
   logic [LW:0]   restore_count = '0;
   logic          restore_push_valid = 1'b0;
   logic          restore_pop_valid = 1'b0;
   logic [PW-1:0] restore_push_pc38 = '0;
   logic [PW-1:0] top_pc38;
   logic [LW-1:0] ras_index;
   logic [LW:0]   ras_count;
   logic          empty;
   logic          full;

   typedef struct {
      string         name;
      logic [LW-1:0] idx;
      logic [LW:0]   cnt;
      logic [PW-1:0] top;
      logic          emp;
      logic          ful;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   ras_ckpt_stack #(.RAS_ENTRIES(N), .PC_WIDTH(PW)) dut (
      .CLK(CLK),
      .rst(rst),
      .push_valid(push_valid),
      .push_pc38(push_pc38),
      .pop_valid(pop_valid),
      .restore_valid(restore_valid),
      .restore_index(restore_index),
      .restore_count(restore_count),
      .restore_push_valid(restore_push_valid),
      .restore_pop_valid(restore_pop_valid),
      .restore_push_pc38(restore_push_pc38),
      .top_pc38(top_pc38),
      .ras_index(ras_index),
      .ras_count(ras_count),
      .empty(empty),
      .full(full)
   );

   always #5 CLK = ~CLK;

   // Monitor: drain expectations against outputs at mid-cycle.
   always @(negedge CLK) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (ras_index !== e.idx || ras_count !== e.cnt ||
             top_pc38 !== e.top || empty !== e.emp ||
             full !== e.ful) begin
            errors++;
            $display("FAIL %s: got idx=%0d cnt=%0d top=%h e=%b f=%b, want idx=%0d cnt=%0d top=%h e=%b f=%b",
                     e.name, ras_index, ras_count, top_pc38, empty, full,
                     e.idx, e.cnt, e.top, e.emp, e.ful);
         end
      end
   end

   task automatic cyc(input logic r, input logic ps,
                      input logic [PW-1:0] pc, input logic pp,
                      input logic rv, input logic [LW-1:0] ri,
                      input logic [LW:0] rc, input logic rps,
                      input logic [PW-1:0] rpc, input logic rpp);
      rst = r;
      push_valid = ps;
      push_pc38 = pc;
      pop_valid = pp;
      restore_valid = rv;
      restore_index = ri;
      restore_count = rc;
      restore_push_valid = rps;
      restore_push_pc38 = rpc;
      restore_pop_valid = rpp;
      @(posedge CLK);
      #1;
      rst = 1'b0;
      push_valid = 1'b0;
      pop_valid = 1'b0;
      restore_valid = 1'b0;
      restore_push_valid = 1'b0;
      restore_pop_valid = 1'b0;
   endtask

   task automatic exp(input string n, input int i, input int c,
                      input logic [PW-1:0] t, input logic e,
                      input logic f);
      exp_t x;
      x.name = n;
      x.idx = LW'(i);
      x.cnt = (LW+1)'(c);
      x.top = t;
      x.emp = e;
      x.ful = f;
      q.push_back(x);
   endtask

   task automatic do_rst();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_push(input logic [PW-1:0] pc);
      cyc(0, 1, pc, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_pop();
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_rest(input int ri, input int rc, input logic rps,
                          input logic [PW-1:0] rpc, input logic rpp);
      cyc(0, 0, 0, 0, 1, LW'(ri), (LW+1)'(rc), rps, rpc, rpp);
   endtask

   initial begin
      do_rst();
      do_rst();
      exp("reset", 0, 0, 0, 1, 0);

      do_push(38'h100);
      exp("push100", 1, 1, 38'h100, 0, 0);
      do_push(38'h200);
      exp("push200", 2, 2, 38'h200, 0, 0);
      do_pop();
      exp("pop_after2", 1, 1, 38'h100, 0, 0);

      do_rst();
      do_pop();
      exp("pop_empty", 15, 0, 0, 1, 0);

      do_rst();
      for (int k = 1; k <= 3; k++) do_push(PW'(k));
      exp("three_push", 3, 3, 3, 0, 0);
      do_push(38'hABC);
      cyc(0, 1, 38'hABC, 1, 0, 0, 0, 0, 0, 0);
      exp("push_pop", 4, 4, 38'hABC, 0, 0);
      do_pop();
      exp("pop_after_pp", 3, 3, 3, 0, 0);
      cyc(0, 1, 38'hDEF, 1, 0, 0, 0, 0, 0, 0);
      exp("push_pop_3", 3, 3, 38'hDEF, 0, 0);
      do_pop();
      exp("pop_keeps2", 2, 2, 2, 0, 0);

      do_rst();
      for (int k = 1; k <= 16; k++) do_push(PW'(k));
      exp("push16_full", 0, 16, 16, 0, 1);
      do_push(17);
      exp("push17_wrap", 1, 16, 17, 0, 1);
      do_pop();
      exp("wrap_pop1", 0, 15, 16, 0, 0);
      do_pop();
      exp("wrap_pop2", 15, 14, 15, 0, 0);
      for (int k = 3; k <= 16; k++) do_pop();
      exp("wrap_pop16", 1, 0, 17, 1, 0);
      do_pop();
      exp("pop_stale", 0, 0, 16, 1, 0);

      do_rst();
      for (int k = 1; k <= 5; k++) do_push(PW'(38'h10 + k));
      exp("five_push", 5, 5, 38'h15, 0, 0);
      cyc(0, 1, 38'hDEAD, 0, 1, 2, 2, 1, 38'h77, 0);
      exp("restore_push", 3, 3, 38'h77, 0, 0);
      do_pop();
      exp("restore_then_pop", 2, 2, 38'h12, 0, 0);
      cyc(0, 0, 0, 1, 1, 4, 4, 0, 0, 0);
      exp("restore_plain", 4, 4, 38'h14, 0, 0);
      do_rest(3, 3, 0, 0, 0);
      exp("restore_plain2", 3, 3, 38'h77, 0, 0);
      do_rest(7, 31, 1, 38'h99, 0);
      exp("clamp_push", 8, 16, 38'h99, 0, 1);
      do_rest(5, 20, 0, 0, 0);
      exp("clamp_plain", 5, 16, 38'h15, 0, 1);
      do_rest(0, 0, 0, 0, 1);
      exp("restore_pop", 15, 0, 0, 1, 0);
      do_rest(5, 5, 1, 38'h55, 1);
      exp("restore_pp", 5, 5, 38'h55, 0, 0);
      do_rest(8, 16, 0, 0, 1);
      exp("restore_pop_full", 7, 15, 0, 0, 0);

      cyc(1, 1, 38'h1, 0, 1, 6, 6, 1, 38'h66, 0);
      exp("rst_over_restore", 0, 0, 0, 1, 0);
      do_rest(5, 0, 0, 0, 0);
      exp("rst_wiped", 5, 0, 0, 1, 0);

      repeat (3) @(negedge CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      done = 1'b1;
      $finish;
   end

   initial begin
      #20000;
      if (!done) begin
         $display("FAIL timeout: got no finish, want finish");
         $fatal(1, "timeout");
      end
   end

endmodule
